// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: data-memory handshake FSM, multi-cycle MDU tracking,
// and priority-resolved stall/bubble generation for the F/D/E/M/W stage registers.
module pipeline_ctrl #(
  parameter int unsigned MUL_CYC = 4,
  parameter int unsigned DIV_CYC = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic       d_use_rs,
  input  logic       d_use_rt,
  input  logic [4:0] e_rn,
  input  logic       e_wreg,
  input  logic       e_m2reg,
  input  logic       e_do_jmp,
  input  logic       e_mdu_start,
  input  logic       e_mdu_div,
  input  logic       m_wreg,
  input  logic       m_m2reg,
  input  logic       m_wmem,
  input  logic       m_do_jmp_in_m,
  input  logic       dmem_ack,
  output logic       f_stall,
  output logic       d_stall,
  output logic       e_stall,
  output logic       m_stall,
  output logic       d_bubble,
  output logic       e_bubble,
  output logic       m_bubble,
  output logic       w_bubble,
  output logic       dmem_req,
  output logic       mdu_start
);

  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             dmem_req_q, dmem_req_d;

  logic m_access, mem_wait, accept, mdu_wait, load_use;

  assign m_access = (m_m2reg & m_wreg) | m_wmem;
  assign mem_wait = ((state_q == IDLE) & m_access) | (state_q == REQ);
  assign accept   = e_mdu_start & (cnt_q == '0) & ~done_q & ~mem_wait;
  assign mdu_wait = accept | (cnt_q != '0);
  assign load_use = e_m2reg & e_wreg & (e_rn != 5'd0) &
                    ((d_use_rs & (d_rs == e_rn)) | (d_use_rt & (d_rt == e_rn)));

  // Memory handshake next state; the request flop follows the next state so it is glitch-free.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (m_access) state_d = REQ;
      REQ:     if (dmem_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    dmem_req_d = (state_d == REQ);
  end

  // The counter keeps running under a memory stall; done holds the finished op in E until it moves.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (accept) begin
      cnt_d = e_mdu_div ? CNT_W'(DIV_CYC) : CNT_W'(MUL_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (cnt_q == CNT_W'(1)) begin
      done_d = 1'b1;
    end else if (!e_stall) begin
      done_d = 1'b0;
    end
  end

  always_comb begin
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    e_stall  = 1'b0;
    m_stall  = 1'b0;
    d_bubble = 1'b0;
    e_bubble = 1'b0;
    m_bubble = 1'b0;
    w_bubble = 1'b0;
    if (mem_wait) begin
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      e_stall  = 1'b1;
      m_stall  = 1'b1;
      w_bubble = 1'b1;
    end else if (mdu_wait) begin
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      e_stall  = 1'b1;
      m_bubble = 1'b1;
    end else if (m_do_jmp_in_m) begin
      d_bubble = 1'b1;
      e_bubble = 1'b1;
      m_bubble = 1'b1;
    end else if (e_do_jmp) begin
      d_bubble = 1'b1;
      e_bubble = 1'b1;
    end else if (load_use) begin
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      e_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      dmem_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      dmem_req_q <= dmem_req_d;
    end
  end

  assign dmem_req  = dmem_req_q;
  assign mdu_start = accept;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a priority table plus hand-written
// multi-cycle sequences, compared through an expected-value queue.
module tb_pipeline_ctrl;

  localparam int unsigned MUL = 4;
  localparam int unsigned DIV = 32;

  // Packed expectation: {f,d,e,m stall, d,e,m,w bubble, dmem_req, mdu_start}
  localparam logic [9:0] NONE = 10'b0000000000;
  localparam logic [9:0] LU   = 10'b1100010000;
  localparam logic [9:0] EJ   = 10'b0000110000;
  localparam logic [9:0] MJ   = 10'b0000111000;
  localparam logic [9:0] MEMW = 10'b1111000100;
  localparam logic [9:0] MEMR = 10'b1111000110;
  localparam logic [9:0] MDUW = 10'b1110001000;
  localparam logic [9:0] MDUS = 10'b1110001001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] d_rs, d_rt, e_rn;
  logic       d_use_rs, d_use_rt, e_wreg, e_m2reg, e_do_jmp, e_mdu_start, e_mdu_div;
  logic       m_wreg, m_m2reg, m_wmem, m_do_jmp_in_m, dmem_ack;
  logic       f_stall, d_stall, e_stall, m_stall;
  logic       d_bubble, e_bubble, m_bubble, w_bubble, dmem_req, mdu_start;

  pipeline_ctrl #(.MUL_CYC(MUL), .DIV_CYC(DIV)) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .e_rn(e_rn), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_do_jmp(e_do_jmp),
    .e_mdu_start(e_mdu_start), .e_mdu_div(e_mdu_div),
    .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_wmem(m_wmem), .m_do_jmp_in_m(m_do_jmp_in_m),
    .dmem_ack(dmem_ack),
    .f_stall(f_stall), .d_stall(d_stall), .e_stall(e_stall), .m_stall(m_stall),
    .d_bubble(d_bubble), .e_bubble(e_bubble), .m_bubble(m_bubble), .w_bubble(w_bubble),
    .dmem_req(dmem_req), .mdu_start(mdu_start)
  );

  typedef struct {
    logic       reset;
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic       d_use_rs;
    logic       d_use_rt;
    logic [4:0] e_rn;
    logic       e_wreg;
    logic       e_m2reg;
    logic       e_do_jmp;
    logic       e_mdu_start;
    logic       e_mdu_div;
    logic       m_wreg;
    logic       m_m2reg;
    logic       m_wmem;
    logic       m_jmp;
    logic       dmem_ack;
  } vec_t;

  typedef struct {
    vec_t       v;
    logic [9:0] exp;
  } row_t;

  int         total = 0;
  int         bad   = 0;
  logic [9:0] sb[$];

  function automatic vec_t z();
    vec_t r;
    r.reset = 1'b0; r.d_rs = '0; r.d_rt = '0; r.d_use_rs = 1'b0; r.d_use_rt = 1'b0;
    r.e_rn = '0; r.e_wreg = 1'b0; r.e_m2reg = 1'b0; r.e_do_jmp = 1'b0;
    r.e_mdu_start = 1'b0; r.e_mdu_div = 1'b0; r.m_wreg = 1'b0; r.m_m2reg = 1'b0;
    r.m_wmem = 1'b0; r.m_jmp = 1'b0; r.dmem_ack = 1'b0;
    return r;
  endfunction

  function automatic vec_t lu(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                              input logic urt, input logic [4:0] ern, input logic ew,
                              input logic em);
    vec_t r = z();
    r.d_rs = rs; r.d_rt = rt; r.d_use_rs = urs; r.d_use_rt = urt;
    r.e_rn = ern; r.e_wreg = ew; r.e_m2reg = em;
    return r;
  endfunction

  function automatic row_t row(input vec_t v, input logic [9:0] e);
    row_t r;
    r.v = v;
    r.exp = e;
    return r;
  endfunction

  task automatic apply(input vec_t v);
    reset = v.reset; d_rs = v.d_rs; d_rt = v.d_rt; d_use_rs = v.d_use_rs; d_use_rt = v.d_use_rt;
    e_rn = v.e_rn; e_wreg = v.e_wreg; e_m2reg = v.e_m2reg; e_do_jmp = v.e_do_jmp;
    e_mdu_start = v.e_mdu_start; e_mdu_div = v.e_mdu_div; m_wreg = v.m_wreg;
    m_m2reg = v.m_m2reg; m_wmem = v.m_wmem; m_do_jmp_in_m = v.m_jmp; dmem_ack = v.dmem_ack;
  endtask

  // Drive one cycle just after the rising edge, compare at the falling edge.
  task automatic step(input vec_t v, input logic [9:0] exp, input string nm);
    logic [9:0] got, want;
    @(posedge clk);
    #1;
    apply(v);
    sb.push_back(exp);
    @(negedge clk);
    got  = {f_stall, d_stall, e_stall, m_stall, d_bubble, e_bubble, m_bubble, w_bubble,
            dmem_req, mdu_start};
    want = sb.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", nm, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t tbl[15];
    vec_t v, r;

    tbl[0]  = row(z(), NONE);
    tbl[1]  = row(lu(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1), LU);
    tbl[2]  = row(lu(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1), NONE);
    tbl[3]  = row(lu(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1), NONE);
    tbl[4]  = row(lu(5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1), LU);
    tbl[5]  = row(lu(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1), NONE);
    tbl[6]  = row(lu(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0), NONE);
    tbl[7]  = row(lu(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1), LU);
    v = z(); v.e_do_jmp = 1'b1;
    tbl[8]  = row(v, EJ);
    v = lu(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1); v.e_do_jmp = 1'b1;
    tbl[9]  = row(v, EJ);
    v = z(); v.m_jmp = 1'b1;
    tbl[10] = row(v, MJ);
    v = lu(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1); v.m_jmp = 1'b1;
    tbl[11] = row(v, MJ);
    v = z(); v.m_wreg = 1'b1;
    tbl[12] = row(v, NONE);
    v = z(); v.m_m2reg = 1'b1;
    tbl[13] = row(v, NONE);
    v = z(); v.m_jmp = 1'b1; v.e_do_jmp = 1'b1;
    tbl[14] = row(v, MJ);

    r = z(); r.reset = 1'b1;
    apply(r);
    step(r, NONE, "reset_hold0");
    step(r, NONE, "reset_hold1");

    foreach (tbl[i]) step(tbl[i].v, tbl[i].exp, $sformatf("tbl%0d", i));

    // Load in M, ack on the third request cycle.
    v = z(); v.m_m2reg = 1'b1; v.m_wreg = 1'b1;
    step(v, MEMW, "ld_idle_wait");
    step(v, MEMR, "ld_req1");
    step(v, MEMR, "ld_req2");
    v.dmem_ack = 1'b1;
    step(v, MEMR, "ld_req3_ack");
    v.dmem_ack = 1'b0;
    step(v, NONE, "ld_done");
    step(z(), NONE, "ld_back_idle");

    // Divide: accept + DIV stall cycles, then free with no relaunch.
    v = z(); v.e_mdu_start = 1'b1; v.e_mdu_div = 1'b1;
    step(v, MDUS, "div_accept");
    for (int i = 0; i < int'(DIV); i++) step(v, MDUW, $sformatf("div_busy%0d", i));
    step(v, NONE, "div_release");
    step(z(), NONE, "div_after");

    // Multiply.
    v = z(); v.e_mdu_start = 1'b1;
    step(v, MDUS, "mul_accept");
    for (int i = 0; i < int'(MUL); i++) step(v, MDUW, $sformatf("mul_busy%0d", i));
    step(v, NONE, "mul_release");
    step(z(), NONE, "mul_after");

    // Multiply overlapped by a long store: memory wait dominates, counter drains underneath.
    v = z(); v.e_mdu_start = 1'b1;
    step(v, MDUS, "ms_accept");
    v.m_wmem = 1'b1;
    step(v, MEMW, "ms_idle_wait");
    for (int i = 0; i < 5; i++) step(v, MEMR, $sformatf("ms_req%0d", i));
    v.dmem_ack = 1'b1;
    step(v, MEMR, "ms_req_ack");
    v.dmem_ack = 1'b0;
    step(v, NONE, "ms_done_e_moves");
    step(z(), NONE, "ms_after");

    // Reset while a request is outstanding.
    v = z(); v.m_wmem = 1'b1;
    step(v, MEMW, "rq_idle_wait");
    step(v, MEMR, "rq_req");
    r = z(); r.reset = 1'b1;
    step(r, MEMR, "rq_reset_sampled");
    step(r, NONE, "rq_reset_cleared");
    step(z(), NONE, "rq_released");

    // Reset in the middle of a divide, then a fresh multiply launches.
    v = z(); v.e_mdu_start = 1'b1; v.e_mdu_div = 1'b1;
    step(v, MDUS, "rm_accept");
    step(v, MDUW, "rm_busy");
    step(r, MDUW, "rm_reset_sampled");
    step(z(), NONE, "rm_cnt_cleared");
    v = z(); v.e_mdu_start = 1'b1;
    step(v, MDUS, "rm_relaunch");
    for (int i = 0; i < int'(MUL); i++) step(v, MDUW, $sformatf("rm_busy%0d", i));
    step(v, NONE, "rm_release");
    step(z(), NONE, "rm_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MUL_CYC, default 4, MDU busy cycles for multiply.
REQ-002 Parameter DIV_CYC, default 32, MDU busy cycles for divide; both 1..63.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 d_rs, d_rt  in  5 each  source register numbers of instruction in D.
REQ-006 d_use_rs, d_use_rt  in  1 each  D instruction reads rs / rt.
REQ-007 e_rn, e_wreg, e_m2reg  in  5,1,1  E destination, register write, load.
REQ-008 e_do_jmp  in  1  control transfer resolved in E.
REQ-009 e_mdu_start, e_mdu_div  in  1,1  E holds an MDU op; 1 = divide, 0 = multiply.
REQ-010 m_wreg, m_m2reg, m_wmem, m_do_jmp_in_m  in  1 each  M-stage controls.
REQ-011 dmem_ack  in  1  data memory completes the outstanding request.
REQ-012 f_stall, d_stall, e_stall, m_stall  out  1 each  hold stage register.
REQ-013 d_bubble, e_bubble, m_bubble, w_bubble  out  1 each  load bubble into stage register.
REQ-014 dmem_req  out  1  registered data memory request.
REQ-015 mdu_start  out  1  one-cycle MDU launch pulse.

Function
REQ-016 m_access = (m_m2reg & m_wreg) | m_wmem.
REQ-017 Memory FSM states IDLE, REQ, DONE; IDLE->REQ when m_access; REQ->DONE when dmem_ack; DONE->IDLE unconditionally.
REQ-018 dmem_req = 1 exactly while state == REQ (registered, glitch-free).
REQ-019 mem_wait = (IDLE & m_access) | REQ; in DONE M advances normally.
REQ-020 mem_wait: f/d/e/m_stall = 1, w_bubble = 1, all other bubbles 0; highest priority.
REQ-021 MDU: 6-bit counter cnt and flag done; accept = e_mdu_start & cnt==0 & !done & !mem_wait.
REQ-022 On accept: mdu_start = 1 that cycle; cnt loads DIV_CYC if e_mdu_div else MUL_CYC.
REQ-023 cnt decrements every cycle while nonzero, including during mem_wait; on 1->0 transition done sets.
REQ-024 done clears on any cycle with e_stall == 0.
REQ-025 mdu_wait = accept | cnt != 0; when !mem_wait: f/d/e_stall = 1, m_bubble = 1.
REQ-026 Result: MDU op stalls in E for 1 + N cycles (N = MUL_CYC or DIV_CYC), advances on next cycle.
REQ-027 Else m_do_jmp_in_m: d_bubble = e_bubble = m_bubble = 1, no stalls.
REQ-028 Else e_do_jmp: d_bubble = e_bubble = 1, no stalls.
REQ-029 Else load_use = e_m2reg & e_wreg & e_rn != 0 & ((d_use_rs & d_rs == e_rn) | (d_use_rt & d_rt == e_rn)): f/d_stall = 1, e_bubble = 1.
REQ-030 Else all stall and bubble outputs 0.
REQ-031 Priority is strict: mem_wait > mdu_wait > m jump > e jump > load_use.
REQ-032 Stall and bubble for the same stage never both 1.
REQ-033 Stall/bubble outputs combinational from inputs plus state; no input-to-dmem_req combinational path.

Reset
REQ-034 On reset: state IDLE, cnt 0, done 0, dmem_req 0; takes effect at the next edge.
REQ-035 Reset mid-access or mid-MDU abandons the operation; dmem_req drops the cycle after reset is sampled.
REQ-036 With reset asserted and all inputs 0, all outputs 0.

Verification
REQ-037 Load in M, dmem_ack 3 cycles after dmem_req -> mem_wait for 4 cycles, DONE 1 cycle, then IDLE; dmem_req high exactly 3 cycles.
REQ-038 e_mdu_start, e_mdu_div = 1, DIV_CYC 32 -> mdu_start one pulse; f/d/e_stall high 33 cycles; m_bubble high 33 cycles; no second pulse.
REQ-039 Load e_rn = 5 in E, D reads rs = 5 -> f/d_stall = 1, e_bubble = 1 for 1 cycle; e_rn = 0 -> no stall.
REQ-040 m_do_jmp_in_m and load_use together -> d/e/m_bubble = 1, no stalls.
REQ-041 Multiply started, store in M with ack 6 cycles later -> mem_wait dominates; cnt reaches 0 during wait; E advances on the first cycle after DONE.
REQ-042 Reset in REQ -> dmem_req 0 next cycle; state IDLE; cnt 0.
